pipe_ctrl: RTL

Hazard and status controller for the five-stage Y86-64 pipeline. It watches the stage registers (D, E, M, W) and the fetch/execute/memory outputs, and produces the per-stage stall and bubble strobes consumed by the F/D/E/M/W pipeline registers. It also owns the registered processor status FSM that freezes the machine on halt or fault, plus optional cycle and retirement counters. It sits beside the datapath in the top-level processor and replaces the ad-hoc `stat` logic there.

---
 rtl/pipe_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Hazard/status controller for the five-stage Y86-64 pipeline: stall and bubble strobes,
// halt/fault status FSM, and optional cycle/retire counters (enabled by PIPE_PERF_CNT_EN).
module pipe_ctrl #(
    parameter int STAT_W = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        M_icode,
    input  logic [3:0]        W_icode,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    input  logic [3:0]        E_dstM,
    input  logic              e_Cnd,
    input  logic [STAT_W-1:0] m_stat,
    input  logic [STAT_W-1:0] W_stat,
    output logic              F_stall,
    output logic              D_stall,
    output logic              W_stall,
    output logic              D_bubble,
    output logic              E_bubble,
    output logic              M_bubble,
    output logic              set_cc_en,
    output logic [STAT_W-1:0] cpu_stat,
    output logic              halted,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  ret_cnt
);

    localparam logic [STAT_W-1:0] STAT_AOK = STAT_W'(1);
    localparam logic [STAT_W-1:0] STAT_ADR = STAT_W'(2);
    localparam logic [STAT_W-1:0] STAT_HLT = STAT_W'(4);

    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE     = 4'hF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t stateQ, stateD;

    function automatic logic isMemLoad(input logic [3:0] icode);
        return (icode == ICODE_MRMOVQ) || (icode == ICODE_POPQ);
    endfunction

    function automatic logic usesReg(input logic [3:0] dst, input logic [3:0] srcA,
                                     input logic [3:0] srcB);
        return (dst != REG_NONE) && ((dst == srcA) || (dst == srcB));
    endfunction

    logic loadUse;
    logic retHazard;
    logic mispredict;
    logic exception;
    logic wHalt;
    logic wFault;
    logic wNotAok;

    assign loadUse    = isMemLoad(E_icode) && usesReg(E_dstM, d_srcA, d_srcB);
    assign retHazard  = (D_icode == ICODE_RET) || (E_icode == ICODE_RET) || (M_icode == ICODE_RET);
    assign mispredict = (E_icode == ICODE_JXX) && !e_Cnd;
    assign wNotAok    = (W_stat != STAT_AOK);
    assign exception  = (m_stat != STAT_AOK) || wNotAok;
    // HLT takes priority over INS/ADR when a malformed status carries both bits.
    assign wHalt      = (W_stat & STAT_HLT) != '0;
    assign wFault     = (W_stat & STAT_ADR) != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= RUN;
        end else begin
            stateQ <= stateD;
        end
    end

    // Strobes depend on rst_n directly so an asynchronous reset flushes the pipe at once.
    always_comb begin
        stateD    = stateQ;
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        W_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        set_cc_en = 1'b0;
        if (!rst_n) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            case (stateQ)
                RUN: begin
                    if (wHalt) begin
                        stateD = HALTED;
                    end else if (wFault) begin
                        stateD = FAULT;
                    end
                    F_stall   = loadUse || retHazard;
                    // A mispredict squashes D, so it overrides the load/use hold on D.
                    D_stall   = loadUse && !mispredict;
                    D_bubble  = mispredict || (retHazard && !loadUse);
                    E_bubble  = mispredict || loadUse;
                    M_bubble  = exception;
                    W_stall   = wNotAok;
                    set_cc_en = (E_icode == ICODE_OPQ) && !exception;
                end
                HALTED, FAULT: begin
                    F_stall = 1'b1;
                    D_stall = 1'b1;
                    W_stall = 1'b1;
                end
                default: begin
                    stateD  = FAULT;
                    F_stall = 1'b1;
                    D_stall = 1'b1;
                    W_stall = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        cpu_stat = STAT_ADR;
        case (stateQ)
            RUN:     cpu_stat = STAT_AOK;
            HALTED:  cpu_stat = STAT_HLT;
            default: cpu_stat = STAT_ADR;
        endcase
    end

    assign halted = (stateQ != RUN);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cycCntQ;
    logic [CNT_W-1:0] retCntQ;
    logic             retire;

    // Bubbles enter as NOPs, so excluding NOP also excludes flushed slots.
    assign retire = !wNotAok && (W_icode != ICODE_NOP) && !W_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycCntQ <= '0;
            retCntQ <= '0;
        end else if (stateQ == RUN) begin
            cycCntQ <= cycCntQ + CNT_W'(1);
            if (retire) begin
                retCntQ <= retCntQ + CNT_W'(1);
            end
        end
    end

    assign cyc_cnt = cycCntQ;
    assign ret_cnt = retCntQ;
`else
    logic unusedWIcode;
    assign unusedWIcode = ^W_icode;
    assign cyc_cnt      = '0;
    assign ret_cnt      = '0;
`endif

endmodule
